// File: rtl/mips32_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : mips32_fetch_queue
// Brief    : MIPS32 instruction-fetch front end with a small IF/ID queue.
// Revision : 1.0
// ============================================================================
module mips32_fetch_queue #(
    parameter int QDEPTH = 4,
    parameter int AW     = 10,
    parameter int DW     = 32
) (
    input  logic                      clk1,
    input  logic                      rst,
    input  logic                      redirect_valid,
    input  logic [AW-1:0]             redirect_pc,
    input  logic                      halt,
    output logic                      imem_req,
    output logic [AW-1:0]             imem_addr,
    input  logic                      imem_ack,
    input  logic [DW-1:0]             imem_rdata,
    output logic                      if_valid,
    input  logic                      if_ready,
    output logic [DW-1:0]             if_ir,
    output logic [31:0]               if_npc,
    output logic [$clog2(QDEPTH):0]   q_count
);
    localparam int                c_PTR_W   = $clog2(QDEPTH);
    localparam int                c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(QDEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [AW-1:0]      c_PC_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [AW-1:0]       r_pc, w_pc_nxt;
    logic [AW-1:0]       r_addr, w_addr_nxt;
    logic                r_halted;
    logic                r_drop, w_drop_nxt;
    logic [DW-1:0]       r_ir_mem  [QDEPTH];
    logic [AW-1:0]       r_npc_mem [QDEPTH];
    logic [c_PTR_W-1:0]  r_head, r_tail;
    logic [c_CNT_W-1:0]  r_count, w_count_nxt;

    logic                w_ack, w_enq, w_deq, w_halt_any;
    logic [AW-1:0]       w_seq_pc;

    assign w_ack      = (r_state == S_REQ) && imem_ack;
    // A redirect in the ack cycle squashes the returning word as well.
    assign w_enq      = w_ack && !r_drop && !redirect_valid;
    assign w_deq      = (r_count != '0) && if_ready;
    assign w_halt_any = r_halted | halt;
    assign w_seq_pc   = r_addr + c_PC_ONE;

    always_comb begin
        w_count_nxt = r_count;
        if (redirect_valid)
            w_count_nxt = '0;
        else if (w_enq && !w_deq)
            w_count_nxt = r_count + c_CNT_ONE;
        else if (!w_enq && w_deq)
            w_count_nxt = r_count - c_CNT_ONE;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_addr;
        w_drop_nxt  = r_drop;
        if (w_enq)
            w_pc_nxt = w_seq_pc;
        if (redirect_valid)
            w_pc_nxt = redirect_pc;
        case (r_state)
            S_IDLE: begin
                if (w_halt_any) begin
                    w_state_nxt = S_HALT;
                end else if (r_count < c_FULL) begin
                    w_state_nxt = S_REQ;
                    w_addr_nxt  = w_pc_nxt;
                end
            end
            S_REQ: begin
                if (w_ack) begin
                    w_drop_nxt = 1'b0;
                    if (w_halt_any) begin
                        w_state_nxt = S_HALT;
                    end else if (w_count_nxt < c_FULL) begin
                        w_addr_nxt = w_pc_nxt;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (redirect_valid) begin
                    // Request stays on the bus; its data is thrown away on ack.
                    w_drop_nxt = 1'b1;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_addr   <= '0;
            r_halted <= 1'b0;
            r_drop   <= 1'b0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_addr   <= w_addr_nxt;
            r_halted <= w_halt_any;
            r_drop   <= w_drop_nxt;
            r_count  <= w_count_nxt;
            if (redirect_valid) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_enq)
                    r_tail <= r_tail + c_PTR_ONE;
                if (w_deq)
                    r_head <= r_head + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (w_enq) begin
            r_ir_mem[r_tail]  <= imem_rdata;
            r_npc_mem[r_tail] <= w_seq_pc;
        end
    end

    assign imem_req  = (r_state == S_REQ);
    assign imem_addr = r_addr;
    assign if_valid  = (r_count != '0);
    assign if_ir     = if_valid ? r_ir_mem[r_head] : '0;
    assign if_npc    = if_valid ? 32'(r_npc_mem[r_head]) : 32'd0;
    assign q_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mips32_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips32_fetch_queue
// Brief    : Self-checking bench for mips32_fetch_queue with a transaction model.
// Revision : 1.0
// ============================================================================
module tb_mips32_fetch_queue;
    localparam int QDEPTH = 4;
    localparam int AW     = 10;
    localparam int DW     = 32;

    logic                    clk1 = 1'b0;
    logic                    rst = 1'b1;
    logic                    redirect_valid = 1'b0;
    logic [AW-1:0]           redirect_pc = '0;
    logic                    halt = 1'b0;
    logic                    imem_req;
    logic [AW-1:0]           imem_addr;
    logic                    imem_ack = 1'b0;
    logic [DW-1:0]           imem_rdata = '0;
    logic                    if_valid;
    logic                    if_ready = 1'b0;
    logic [DW-1:0]           if_ir;
    logic [31:0]             if_npc;
    logic [$clog2(QDEPTH):0] q_count;

    mips32_fetch_queue #(.QDEPTH(QDEPTH), .AW(AW), .DW(DW)) u_dut (
        .clk1(clk1), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_ir(if_ir), .if_npc(if_npc), .q_count(q_count)
    );

    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 0;
    int wait_cnt = 0;
    bit stray    = 1'b0;

    // Transaction-level model: queue of fetched words plus the one open request.
    typedef struct {
        logic [31:0] ir;
        logic [31:0] npc;
    } entry_t;
    entry_t mq[$];
    bit     m_req, m_drop, m_halted;
    int     m_pc, m_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit done;
        bit was_req;
        int sz0;
        entry_t e;
        if (rst) begin
            mq.delete();
            m_req = 0; m_drop = 0; m_halted = 0; m_pc = 0; m_addr = 0;
            return;
        end
        done    = 0;
        was_req = m_req;
        sz0     = mq.size();
        if (sz0 > 0 && if_ready)
            void'(mq.pop_front());
        if (m_req && imem_ack) begin
            done  = 1;
            m_req = 0;
            if (!m_drop && !redirect_valid) begin
                e.ir  = imem_rdata;
                e.npc = (m_addr + 1) % (1 << AW);
                mq.push_back(e);
                m_pc = (m_addr + 1) % (1 << AW);
            end
            m_drop = 0;
        end
        if (redirect_valid) begin
            mq.delete();
            m_pc = int'(redirect_pc);
            if (m_req) m_drop = 1;
        end
        m_halted = m_halted || halt;
        if (done) begin
            if (!m_halted && mq.size() < QDEPTH) begin
                m_req = 1; m_addr = m_pc;
            end
        end else if (!was_req && !m_halted && sz0 < QDEPTH) begin
            m_req = 1; m_addr = m_pc;
        end
    endtask

    task automatic compare_all();
        chk("imem_req", imem_req, m_req);
        if (m_req) chk("imem_addr", imem_addr, m_addr);
        chk("if_valid", if_valid, mq.size() > 0);
        chk("if_ir", if_ir, (mq.size() > 0) ? mq[0].ir : 32'd0);
        chk("if_npc", if_npc, (mq.size() > 0) ? mq[0].npc : 32'd0);
        chk("q_count", q_count, mq.size());
    endtask

    // Memory returns Mem[a] = a + 100 after 'lat' wait cycles.
    task automatic drive_mem();
        if (imem_req) begin
            imem_ack   = (wait_cnt >= lat);
            imem_rdata = 32'(imem_addr) + 32'd100;
            wait_cnt   = imem_ack ? 0 : wait_cnt + 1;
        end else begin
            imem_ack   = stray && ($urandom_range(0, 3) == 0);
            imem_rdata = $urandom;
            wait_cnt   = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        model_step();
        @(negedge clk1);
        compare_all();
        drive_mem();
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; halt = 1'b0;
        tick(); tick();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_ir", if_ir, 0);
        chk("rst_npc", if_npc, 0);
        chk("rst_count", q_count, 0);
        rst = 1'b0;
    endtask

    task automatic wait_req_addr(input int a, input int budget);
        int k = 0;
        while (!(imem_req === 1'b1 && imem_addr == AW'(a)) && k < budget) begin
            tick(); k++;
        end
        chk("wait_req_addr", (imem_req === 1'b1 && imem_addr == AW'(a)), 1);
    endtask

    task automatic wait_req_low(input int budget);
        int k = 0;
        while (imem_req !== 1'b0 && k < budget) begin
            tick(); k++;
        end
        chk("wait_req_low", imem_req, 0);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (if_valid !== 1'b1 && k < budget) begin
            tick(); k++;
        end
        chk("wait_valid", if_valid, 1);
    endtask

    task automatic wait_empty(input int budget);
        int k = 0;
        while (q_count != 0 && k < budget) begin
            tick(); k++;
        end
        chk("wait_empty", q_count, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Streaming with a zero-wait memory and an always-ready decoder.
        lat = 0; if_ready = 1'b1;
        do_reset();
        tick();
        chk("A_first_req", imem_req, 1);
        chk("A_first_addr", imem_addr, 0);
        tick(); chk("A_ir0", if_ir, 100); chk("A_npc0", if_npc, 1);
        tick(); chk("A_ir1", if_ir, 101); chk("A_npc1", if_npc, 2);
        tick(); chk("A_ir2", if_ir, 102); chk("A_npc2", if_npc, 3);

        // Fill to full, then free one slot.
        if_ready = 1'b0;
        do_reset();
        repeat (5) tick();
        chk("B_full_count", q_count, 4);
        chk("B_full_req", imem_req, 0);
        tick();
        chk("B_still_idle", imem_req, 0);
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        chk("B_count3", q_count, 3);
        chk("B_req_late", imem_req, 0);
        tick();
        chk("B_req4", imem_req, 1);
        chk("B_addr4", imem_addr, 4);

        // Redirect while a slow request is outstanding.
        lat = 3; if_ready = 1'b1;
        do_reset();
        wait_req_addr(5, 100);
        tick();
        redirect_valid = 1'b1; redirect_pc = 10'd20;
        tick();
        redirect_valid = 1'b0;
        chk("C_hold_req", imem_req, 1);
        chk("C_hold_addr", imem_addr, 5);
        chk("C_flushed", q_count, 0);
        wait_req_addr(20, 20);
        wait_valid(20);
        chk("C_ir20", if_ir, 120);
        chk("C_npc20", if_npc, 21);

        // Redirect coinciding with ack.
        lat = 0; if_ready = 1'b1;
        do_reset();
        wait_req_addr(7, 50);
        redirect_valid = 1'b1; redirect_pc = 10'd40;
        tick();
        redirect_valid = 1'b0;
        chk("D_count0", q_count, 0);
        chk("D_req40", imem_req, 1);
        chk("D_addr40", imem_addr, 40);
        tick();
        chk("D_ir40", if_ir, 140);
        chk("D_npc40", if_npc, 41);

        // Halt with a request outstanding and two entries queued.
        lat = 2; if_ready = 1'b0;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 10'd7;
        tick();
        redirect_valid = 1'b0;
        chk("E_req7", imem_addr, 7);
        wait_req_addr(9, 50);
        chk("E_count2", q_count, 2);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        wait_req_low(20);
        chk("E_count3", q_count, 3);
        chk("E_head", if_ir, 107);
        repeat (8) begin
            tick();
            chk("E_no_req", imem_req, 0);
        end
        if_ready = 1'b1;
        wait_empty(20);
        chk("E_drained", if_valid, 0);
        repeat (5) begin
            tick();
            chk("E_halted", imem_req, 0);
        end

        // PC wrap at the top of the address space.
        lat = 0; if_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 10'd1023;
        tick();
        redirect_valid = 1'b0;
        chk("F_addr1023", imem_addr, 1023);
        tick();
        chk("F_ir", if_ir, 1123);
        chk("F_npc_wrap", if_npc, 0);
        chk("F_addr_wrap", imem_addr, 0);

        // Randomized traffic against the model.
        stray = 1'b1;
        for (int blk = 0; blk < 8; blk++) begin
            int rdy_pct;
            lat     = $urandom_range(0, 3);
            rdy_pct = $urandom_range(20, 95);
            for (int c = 0; c < 500; c++) begin
                if_ready       = ($urandom_range(0, 99) < rdy_pct);
                redirect_valid = ($urandom_range(0, 15) == 0);
                redirect_pc    = AW'($urandom);
                halt           = ($urandom_range(0, 399) == 0);
                rst            = ($urandom_range(0, 199) == 0);
                tick();
            end
        end
        rst = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
